eth_bringup_sequencer: RTL and testbench

Autonomous bring-up controller for the AXI Ethernet example subsystem. It replaces manual VIO control of the clock/MAC resets, `start_config` and the 4-bit control command channel. It sequences reset → MMCM lock → MAC configuration → command issue, then supervises running traffic through the packet-checker error flag. It sits in the `axi_lite_clk` domain between the board top level, `axi_ethernet_0_clocks_resets` and `axi_ethernet_0_example`.

---
 rtl/eth_bringup_sequencer.sv | 167 ++++++++++++++++
 tb/tb_eth_bringup_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_bringup_sequencer.sv
// Autonomous bring-up controller for the AXI Ethernet example: reset -> MMCM lock ->
// MAC configuration -> command issue, then supervision of packet-checker errors.
module eth_bringup_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CFG_WAIT     = 64,
    parameter int unsigned NUM_CMDS     = 4,
    parameter logic [15:0] CMD_SEQ      = 16'h4321,
    parameter int unsigned ERR_THRESH   = 8
) (
    input  logic       axi_lite_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       mmcm_locked,
    input  logic       mtrlb_pktchk_error,
    input  logic       control_ready,
    output logic       clk_rst,
    output logic       mac_rst,
    output logic       start_config,
    output logic [3:0] control_data,
    output logic       control_valid,
    output logic [2:0] state,
    output logic       done,
    output logic       fail,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_CONFIG    = 3'd3,
        S_CMD       = 3'd4,
        S_RUN       = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > CFG_WAIT) ? MAX_A : CFG_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(CFG_WAIT);
    localparam logic [1:0]       LAST_CMD  = (NUM_CMDS > 0) ? 2'(NUM_CMDS - 1) : 2'd0;
    localparam logic [7:0]       THRESH    = 8'(ERR_THRESH);

    state_t           cur_state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       cmd_idx, idx_next;
    logic             start_q;
    logic             lock_meta, lock_sync;
    logic             err_meta, err_sync, err_sync_d;
    logic [7:0]       err_next, err_inc;
    logic             err_rise, xfer;
    logic             clk_rst_d, mac_rst_d, start_config_d, control_valid_d, done_d, fail_d;
    logic [3:0]       control_data_d;

    assign state = cur_state;

    // Registered state, counters, synchronisers and decoded outputs.
    always_ff @(posedge axi_lite_clk) begin
        if (sys_rst) begin
            cur_state     <= S_IDLE;
            cnt           <= '0;
            cmd_idx       <= '0;
            start_q       <= 1'b0;
            lock_meta     <= 1'b0;
            lock_sync     <= 1'b0;
            err_meta      <= 1'b0;
            err_sync      <= 1'b0;
            err_sync_d    <= 1'b0;
            err_count     <= '0;
            clk_rst       <= 1'b0;
            mac_rst       <= 1'b0;
            start_config  <= 1'b0;
            control_data  <= '0;
            control_valid <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
        end else begin
            cur_state     <= next_state;
            cnt           <= cnt_next;
            cmd_idx       <= idx_next;
            start_q       <= start;
            lock_meta     <= mmcm_locked;
            lock_sync     <= lock_meta;
            err_meta      <= mtrlb_pktchk_error;
            err_sync      <= err_meta;
            err_sync_d    <= err_sync;
            err_count     <= err_next;
            clk_rst       <= clk_rst_d;
            mac_rst       <= mac_rst_d;
            start_config  <= start_config_d;
            control_data  <= control_data_d;
            control_valid <= control_valid_d;
            done          <= done_d;
            fail          <= fail_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they align with it.
    always_comb begin
        next_state = cur_state;
        cnt_next   = cnt;
        idx_next   = cmd_idx;
        err_next   = err_count;
        err_inc    = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
        err_rise   = err_sync & ~err_sync_d;
        xfer       = control_valid & control_ready;

        case (cur_state)
            S_IDLE: begin
                if (start_q) next_state = S_RESET;
            end
            S_RESET: begin
                cnt_next = cnt + 1'b1;
                if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_next = cnt + 1'b1;
                if (lock_sync)             next_state = S_CONFIG;
                else if (cnt == LOCK_LAST) next_state = S_FAIL;
            end
            S_CONFIG: begin
                cnt_next = cnt + 1'b1;
                if (!lock_sync)           next_state = S_FAIL;
                else if (cnt == CFG_LAST) next_state = (NUM_CMDS == 0) ? S_RUN : S_CMD;
            end
            S_CMD: begin
                if (!lock_sync) begin
                    next_state = S_FAIL;
                end else if (xfer) begin
                    if (cmd_idx == LAST_CMD) next_state = S_RUN;
                    else                     idx_next   = cmd_idx + 2'd1;
                end
            end
            S_RUN: begin
                if (err_rise) err_next = err_inc;
                if (!lock_sync)                        next_state = S_FAIL;
                else if (err_rise && err_inc >= THRESH) next_state = S_FAIL;
                else if (start_q)                      next_state = S_RESET;
            end
            S_FAIL: begin
                if (start_q) next_state = S_RESET;
            end
            default: next_state = S_IDLE;
        endcase

        // Every state starts its own count and command index from zero.
        if (next_state != cur_state) begin
            cnt_next = '0;
            idx_next = '0;
        end
        if (next_state == S_RESET) err_next = '0;

        clk_rst_d       = (next_state == S_RESET);
        mac_rst_d       = (next_state == S_RESET) || (next_state == S_WAIT_LOCK) ||
                          (next_state == S_FAIL);
        start_config_d  = (next_state == S_CONFIG) && (cur_state != S_CONFIG);
        control_valid_d = (next_state == S_CMD);
        control_data_d  = control_valid_d ? CMD_SEQ[{idx_next, 2'b00} +: 4] : 4'd0;
        done_d          = (next_state == S_RUN);
        fail_d          = (next_state == S_FAIL);
    end

endmodule

// File: tb/tb_eth_bringup_sequencer.sv
// Directed bench for eth_bringup_sequencer; a monitor checks command transfers against
// a queue of expected words while the main sequence checks timing and status outputs.
module tb_eth_bringup_sequencer;

    logic       axi_lite_clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic       mmcm_locked;
    logic       pktchk_err;
    logic       control_ready;
    logic       clk_rst;
    logic       mac_rst;
    logic       start_config;
    logic [3:0] control_data;
    logic       control_valid;
    logic [2:0] state;
    logic       done;
    logic       fail;
    logic [7:0] err_count;

    int         checks = 0;
    int         passes = 0;
    logic [3:0] exp_q[$];

    always #5 axi_lite_clk = ~axi_lite_clk;

    eth_bringup_sequencer dut (
        .axi_lite_clk       (axi_lite_clk),
        .sys_rst            (sys_rst),
        .start              (start),
        .mmcm_locked        (mmcm_locked),
        .mtrlb_pktchk_error (pktchk_err),
        .control_ready      (control_ready),
        .clk_rst            (clk_rst),
        .mac_rst            (mac_rst),
        .start_config       (start_config),
        .control_data       (control_data),
        .control_valid      (control_valid),
        .state              (state),
        .done               (done),
        .fail               (fail),
        .err_count          (err_count)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge axi_lite_clk);
            #1;
        end
    endtask

    // Pulse start for one cycle; when a command run is expected, queue words 1,2,3,4.
    task automatic applyStimulus(input logic lock, input logic ready, input logic expect_cmds);
        if (expect_cmds) begin
            exp_q.push_back(4'd1);
            exp_q.push_back(4'd2);
            exp_q.push_back(4'd3);
            exp_q.push_back(4'd4);
        end
        mmcm_locked   = lock;
        control_ready = ready;
        start         = 1'b1;
        stepCycles(1);
        start         = 1'b0;
    endtask

    task automatic waitState(input logic [2:0] s, input int limit, input string name);
        int n = 0;
        while (state != s && n < limit) begin
            stepCycles(1);
            n++;
        end
        checkOutput(name, state, s);
    endtask

    task automatic checkIdle(input string p);
        checkOutput({p, "_state"},         state,         0);
        checkOutput({p, "_clk_rst"},       clk_rst,       0);
        checkOutput({p, "_mac_rst"},       mac_rst,       0);
        checkOutput({p, "_start_config"},  start_config,  0);
        checkOutput({p, "_control_valid"}, control_valid, 0);
        checkOutput({p, "_control_data"},  control_data,  0);
        checkOutput({p, "_done"},          done,          0);
        checkOutput({p, "_fail"},          fail,          0);
        checkOutput({p, "_err_count"},     err_count,     0);
    endtask

    // Pops an expected word on every transfer and checks stalled words stay put.
    task automatic runMonitor();
        logic       pend = 1'b0;
        logic [3:0] held = 4'd0;
        int         e;
        forever begin
            @(negedge axi_lite_clk);
            if (pend) begin
                checkOutput("hold_valid", control_valid, 1);
                checkOutput("hold_data",  control_data,  held);
            end
            if (control_valid && control_ready && !sys_rst) begin
                e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
                checkOutput("cmd_data", control_data, e);
            end
            pend = control_valid && !control_ready && !sys_rst;
            held = control_data;
        end
    endtask

    initial begin
        int t, rst_cyc, cfg_pulses, cmd_cyc, wl, first_state, n;

        sys_rst       = 1'b1;
        start         = 1'b0;
        mmcm_locked   = 1'b0;
        pktchk_err    = 1'b0;
        control_ready = 1'b0;
        fork
            runMonitor();
        join_none

        stepCycles(3);
        checkIdle("reset");
        sys_rst       = 1'b0;
        mmcm_locked   = 1'b1;
        control_ready = 1'b1;
        stepCycles(4);
        checkOutput("idle_without_start", state, 0);

        $display("[TB] normal bring-up");
        applyStimulus(1'b1, 1'b1, 1'b1);
        t = 0; rst_cyc = 0; cfg_pulses = 0; cmd_cyc = 0; first_state = -1;
        while (!done && t < 300) begin
            stepCycles(1);
            t++;
            if (t == 1) first_state = state;
            rst_cyc    += int'(clk_rst);
            cfg_pulses += int'(start_config);
            cmd_cyc    += (state == 3'd4) ? 1 : 0;
        end
        checkOutput("state_after_start",  first_state, 1);
        checkOutput("clk_rst_cycles",     rst_cyc,     16);
        checkOutput("start_config_pulses", cfg_pulses, 1);
        checkOutput("cmd_cycles_ready",   cmd_cyc,     4);
        checkOutput("start_to_done",      t,           87);
        checkOutput("run_state",          state,       5);
        checkOutput("run_done",           done,        1);
        checkOutput("normal_queue_empty", exp_q.size(), 0);

        $display("[TB] error supervision");
        repeat (7) begin
            pktchk_err = 1'b1;
            stepCycles(2);
            pktchk_err = 1'b0;
            stepCycles(2);
        end
        checkOutput("err_count_7", err_count, 7);
        checkOutput("done_at_7",   done,      1);
        checkOutput("state_at_7",  state,     5);
        pktchk_err = 1'b1;
        stepCycles(2);
        checkOutput("err_pre_edge_count", err_count, 7);
        checkOutput("err_pre_edge_state", state,     5);
        stepCycles(1);
        checkOutput("err_count_8",      err_count,     8);
        checkOutput("thresh_state",     state,         6);
        checkOutput("thresh_fail",      fail,          1);
        checkOutput("thresh_mac_rst",   mac_rst,       1);
        checkOutput("thresh_clk_rst",   clk_rst,       0);
        checkOutput("thresh_valid",     control_valid, 0);
        checkOutput("thresh_done",      done,          0);
        stepCycles(1);
        pktchk_err = 1'b0;
        stepCycles(2);
        pktchk_err = 1'b1;
        stepCycles(2);
        pktchk_err = 1'b0;
        stepCycles(3);
        checkOutput("err_held_in_fail", err_count, 8);
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycles(1);
        checkOutput("restart_state",   state,     1);
        checkOutput("restart_err_clr", err_count, 0);
        checkOutput("restart_clk_rst", clk_rst,   1);

        $display("[TB] backpressure");
        waitState(3'd4, 200, "reach_cmd_bp");
        cmd_cyc = 1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                control_ready = (j == 2);
                stepCycles(1);
                if (state == 3'd4) cmd_cyc++;
            end
        end
        control_ready = 1'b1;
        checkOutput("cmd_cycles_bp",  cmd_cyc,      12);
        checkOutput("bp_run_state",   state,        5);
        checkOutput("bp_queue_empty", exp_q.size(), 0);

        $display("[TB] lock loss in run");
        mmcm_locked = 1'b0;
        pktchk_err  = 1'b1;
        stepCycles(1);
        checkOutput("lockloss_c1_state", state, 5);
        stepCycles(1);
        checkOutput("lockloss_c2_state", state, 5);
        stepCycles(1);
        checkOutput("lockloss_c3_state", state, 6);
        checkOutput("lockloss_fail",     fail,  1);
        checkOutput("lockloss_done",     done,  0);
        pktchk_err = 1'b0;
        stepCycles(2);

        $display("[TB] lock timeout");
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("timeout_restart_state", state, 1);
        wl = 0; n = 0;
        while (state != 3'd6 && n < 2000) begin
            stepCycles(1);
            n++;
            if (state == 3'd2) wl++;
        end
        checkOutput("wait_lock_cycles", wl,      1024);
        checkOutput("timeout_state",    state,   6);
        checkOutput("timeout_fail",     fail,    1);
        checkOutput("timeout_mac_rst",  mac_rst, 1);
        checkOutput("timeout_clk_rst",  clk_rst, 0);

        $display("[TB] reset mid-operation");
        mmcm_locked = 1'b1;
        stepCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitState(3'd4, 300, "reach_cmd_rst");
        control_ready = 1'b1;
        stepCycles(1);
        control_ready = 1'b0;
        checkOutput("inflight_data",  control_data,  2);
        checkOutput("inflight_valid", control_valid, 1);
        stepCycles(2);
        sys_rst = 1'b1;
        stepCycles(1);
        checkIdle("midrst");
        sys_rst = 1'b0;
        exp_q.delete();
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitState(3'd5, 300, "replay_done_state");
        checkOutput("replay_done",        done,         1);
        checkOutput("replay_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
